// File: rtl/cache_dm_wb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cache_dm_wb
//
// Direct-mapped, write-back, write-allocate cache between the CPU request bus
// and the memory block.
// - Single-word CPU reads and writes are accepted while the cache is idle.
// - Hits are served from the internal arrays.
// - On a miss, a dirty victim line is first written back. The line is then
//   filled from memory. Both transfers use two-word bursts.
//
// Address split (word address): offset = addr[0], index = addr[6:1],
// tag = addr[17:7].
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   cpu_cmd    : 0 NOP, 1 READ, 2 WRITE, 3 reserved (treated as NOP)
//   cpu_addr   : word address, sampled with cpu_cmd
//   cpu_wdata  : write data, sampled with cpu_cmd
//   cpu_rdata  : read data, valid while cpu_resp=1, held until next response
//   cpu_resp   : one-cycle completion pulse
//   cpu_busy   : request in flight, cpu_cmd ignored while high
//   mem_cmd    : 0 NOP, 1 READ_LINE, 2 WRITE_LINE
//   mem_addr   : line base address (bit0=0), valid while mem_cmd!=0
//   mem_wdata  : write-back burst data (word0 with the command, then word1)
//   mem_rdata  : fill burst data (word0 with mem_resp, word1 the cycle after)
//   mem_resp   : memory completion pulse
//
// Optional build macro CACHE_STATS_EN adds two outputs:
//   hit_count  : saturating count of lookups that hit
//   miss_count : saturating count of lookups that missed
// ---------------------------------------------------------------------------
module cache_dm_wb #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpu_cmd,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_resp,
    output logic              cpu_busy,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
`ifdef CACHE_STATS_EN
   ,output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    localparam logic [1:0] CMD_READ       = 2'd1;
    localparam logic [1:0] CMD_WRITE      = 2'd2;
    localparam logic [1:0] MEM_READ_LINE  = 2'd1;
    localparam logic [1:0] MEM_WRITE_LINE = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        WB_CMD,
        WB_D1,
        WB_WAIT,
        FILL_CMD,
        FILL_WAIT,
        FILL_D1,
        RESP
    } state_t;

    state_t state;
    state_t nextState;

    // Latched request
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;
    logic              reqWrite;

    // Line storage
    logic [SETS-1:0]   validBits;
    logic [SETS-1:0]   dirtyBits;
    logic [TAG_W-1:0]  tagArr   [SETS];
    logic [DATA_W-1:0] word0Arr [SETS];
    logic [DATA_W-1:0] word1Arr [SETS];

    logic              reqOffset;
    logic [IDX_W-1:0]  reqIndex;
    logic [TAG_W-1:0]  reqTag;
    logic              accept;
    logic              hit;
    logic              victimDirty;

    assign reqOffset   = reqAddr[0];
    assign reqIndex    = reqAddr[OFF_W +: IDX_W];
    assign reqTag      = reqAddr[ADDR_W-1 -: TAG_W];
    assign accept      = (state == IDLE) &&
                         ((cpu_cmd == CMD_READ) || (cpu_cmd == CMD_WRITE));
    assign hit         = validBits[reqIndex] && (tagArr[reqIndex] == reqTag);
    assign victimDirty = validBits[reqIndex] && dirtyBits[reqIndex];

    // State register. Reset drops any request in flight without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and bus outputs.
    // cpu_busy is low in RESP, so a command that arrives together with
    // cpu_resp meets RESP (which ignores it) and is only accepted in IDLE.
    always_comb begin
        nextState = state;
        cpu_resp  = 1'b0;
        cpu_busy  = 1'b0;
        mem_cmd   = 2'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = LOOKUP;
                end
            end
            LOOKUP: begin
                cpu_busy = 1'b1;
                if (hit) begin
                    nextState = RESP;
                end else if (victimDirty) begin
                    nextState = WB_CMD;
                end else begin
                    nextState = FILL_CMD;
                end
            end
            WB_CMD: begin
                cpu_busy  = 1'b1;
                mem_cmd   = MEM_WRITE_LINE;
                mem_addr  = {tagArr[reqIndex], reqIndex, {OFF_W{1'b0}}};
                mem_wdata = word0Arr[reqIndex];
                nextState = WB_D1;
            end
            WB_D1: begin
                cpu_busy  = 1'b1;
                mem_wdata = word1Arr[reqIndex];
                nextState = WB_WAIT;
            end
            WB_WAIT: begin
                cpu_busy = 1'b1;
                if (mem_resp) begin
                    nextState = FILL_CMD;
                end
            end
            FILL_CMD: begin
                cpu_busy  = 1'b1;
                mem_cmd   = MEM_READ_LINE;
                mem_addr  = {reqTag, reqIndex, {OFF_W{1'b0}}};
                nextState = FILL_WAIT;
            end
            FILL_WAIT: begin
                cpu_busy = 1'b1;
                if (mem_resp) begin
                    nextState = FILL_D1;
                end
            end
            FILL_D1: begin
                cpu_busy  = 1'b1;
                nextState = RESP;
            end
            RESP: begin
                cpu_resp  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Request latch, line status bits and read data.
    // A write that allocates leaves the line dirty because the merged word
    // now differs from memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqAddr   <= '0;
            reqWdata  <= '0;
            reqWrite  <= 1'b0;
            validBits <= '0;
            dirtyBits <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        reqAddr  <= cpu_addr;
                        reqWdata <= cpu_wdata;
                        reqWrite <= (cpu_cmd == CMD_WRITE);
                    end
                end
                LOOKUP: begin
                    if (hit && reqWrite) begin
                        dirtyBits[reqIndex] <= 1'b1;
                    end else if (hit) begin
                        cpu_rdata <= reqOffset ? word1Arr[reqIndex] : word0Arr[reqIndex];
                    end
                end
                WB_WAIT: begin
                    if (mem_resp) begin
                        dirtyBits[reqIndex] <= 1'b0;
                    end
                end
                FILL_D1: begin
                    validBits[reqIndex] <= 1'b1;
                    dirtyBits[reqIndex] <= reqWrite;
                    if (!reqWrite) begin
                        cpu_rdata <= reqOffset ? mem_rdata : word0Arr[reqIndex];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data arrays.
    // word0 of a fill is stored as soon as it arrives, so FILL_D1 only has
    // to store word1 and merge a pending write.
    always_ff @(posedge clk) begin
        case (state)
            LOOKUP: begin
                if (hit && reqWrite) begin
                    if (reqOffset) begin
                        word1Arr[reqIndex] <= reqWdata;
                    end else begin
                        word0Arr[reqIndex] <= reqWdata;
                    end
                end
            end
            FILL_WAIT: begin
                if (mem_resp) begin
                    word0Arr[reqIndex] <= mem_rdata;
                end
            end
            FILL_D1: begin
                tagArr[reqIndex]   <= reqTag;
                word1Arr[reqIndex] <= (reqWrite && reqOffset) ? reqWdata : mem_rdata;
                if (reqWrite && !reqOffset) begin
                    word0Arr[reqIndex] <= reqWdata;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    // Lookup statistics, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else begin
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_dm_wb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cache_dm_wb
//
// Directed testbench for cache_dm_wb.
// - A behavioural memory answers line reads and writes.
// - Expected memory transactions and CPU read data are queued as each
//   request is issued, then popped and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_cache_dm_wb;

    logic        clk;
    logic        rst;
    logic [1:0]  cpu_cmd;
    logic [17:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_resp;
    logic        cpu_busy;
    logic [1:0]  mem_cmd;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int compared   = 0;
    int mismatched = 0;
    int memLatency = 1;

    typedef struct {
        logic [1:0]  cmd;
        logic [17:0] addr;
        logic [15:0] w0;
        logic [15:0] w1;
    } memTxn_t;

    typedef struct {
        bit          isRead;
        logic [15:0] rdata;
    } cpuExp_t;

    memTxn_t     expMem[$];
    cpuExp_t     expCpu[$];
    logic [15:0] memModel [int];

    cache_dm_wb dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cmd   (cpu_cmd),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_resp  (cpu_resp),
        .cpu_busy  (cpu_busy),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
`ifdef CACHE_STATS_EN
       ,.hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case a wait is never satisfied
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, required finish before 500000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] memRead(input logic [17:0] a);
        if (memModel.exists(int'(a))) begin
            return memModel[int'(a)];
        end
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectMem(input logic [1:0] cmd, input logic [17:0] addr,
                             input logic [15:0] w0, input logic [15:0] w1);
        memTxn_t t;
        t.cmd  = cmd;
        t.addr = addr;
        t.w0   = w0;
        t.w1   = w1;
        expMem.push_back(t);
    endtask

    // Issue one CPU request and measure accept-edge to response-edge latency.
    // With pokeAtResp a write is presented in the response cycle; it must be
    // ignored, so the cache is idle one cycle later.
    task automatic applyStimulus(input logic [1:0] op, input logic [17:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expRdata,
                                 input int expLat, input bit pokeAtResp);
        cpuExp_t e;
        int      cyc;
        bit      seen;
        bit      respNow;
        @(negedge clk);
        cpu_cmd   = op;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        e.isRead  = (op == 2'd1);
        e.rdata   = expRdata;
        expCpu.push_back(e);
        @(posedge clk);
        #1 cpu_cmd = 2'd0;
        cyc  = 0;
        seen = 1'b0;
        @(negedge clk);
        checkOutput("cpu_busy_after_accept", 32'(cpu_busy), 32'd1);
        while (!seen && cyc < 200) begin
            if (cyc > 0) begin
                @(negedge clk);
            end
            respNow = cpu_resp;
            if (respNow) begin
                checkOutput("cpu_busy_at_resp", 32'(cpu_busy), 32'd0);
                if (pokeAtResp) begin
                    cpu_cmd   = 2'd2;
                    cpu_addr  = addr ^ 18'h00100;
                    cpu_wdata = 16'hDEAD;
                end
            end
            @(posedge clk);
            cyc++;
            if (respNow) begin
                seen = 1'b1;
            end
        end
        #1 cpu_cmd = 2'd0;
        if (!seen) begin
            checkOutput("cpu_resp_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", 32'(cyc), 32'(expLat));
        end
        if (pokeAtResp) begin
            @(negedge clk);
            checkOutput("cmd_at_resp_ignored", 32'(cpu_busy), 32'd0);
        end
    endtask

    // CPU response monitor: pops the expected result for each cpu_resp
    initial begin
        cpuExp_t e;
        @(negedge clk);
        forever begin
            if (cpu_resp === 1'b1) begin
                if (expCpu.size() == 0) begin
                    checkOutput("cpu_resp_unexpected", 32'(cpu_resp), 32'd0);
                end else begin
                    e = expCpu.pop_front();
                    if (e.isRead) begin
                        checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
                    end
                end
            end
            @(negedge clk);
        end
    end

    // Behavioural memory: checks each burst against the expected queue
    initial begin
        memTxn_t     expTxn;
        bit          haveExp;
        logic [1:0]  c;
        logic [17:0] a;
        logic [15:0] w0;
        logic [15:0] w1;
        int          lat;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        forever begin
            if (rst !== 1'b0 || mem_cmd === 2'd0) begin
                @(negedge clk);
            end else begin
                c       = mem_cmd;
                a       = mem_addr;
                w0      = mem_wdata;
                lat     = memLatency;
                haveExp = (expMem.size() != 0);
                if (haveExp) begin
                    expTxn = expMem.pop_front();
                    checkOutput("mem_cmd", 32'(c), 32'(expTxn.cmd));
                    checkOutput("mem_addr", 32'(a), 32'(expTxn.addr));
                end else begin
                    checkOutput("mem_cmd_unexpected", 32'(c), 32'd0);
                end
                @(negedge clk);
                checkOutput("mem_cmd_one_cycle", 32'(mem_cmd), 32'd0);
                if (c == 2'd2) begin
                    w1 = mem_wdata;
                    if (haveExp) begin
                        checkOutput("mem_wdata_word0", 32'(w0), 32'(expTxn.w0));
                        checkOutput("mem_wdata_word1", 32'(w1), 32'(expTxn.w1));
                    end
                    memModel[int'(a)]              = w0;
                    memModel[int'({a[17:1], 1'b1})] = w1;
                    repeat (lat) @(negedge clk);
                    mem_resp = 1'b1;
                    @(negedge clk);
                    mem_resp = 1'b0;
                end else begin
                    repeat (lat - 1) @(negedge clk);
                    mem_resp  = 1'b1;
                    mem_rdata = memRead(a);
                    @(negedge clk);
                    mem_resp  = 1'b0;
                    mem_rdata = memRead({a[17:1], 1'b1});
                    @(negedge clk);
                    mem_rdata = '0;
                end
            end
        end
    end

    // Directed sequence
    initial begin
        rst       = 1'b1;
        cpu_cmd   = 2'd0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        memModel[int'(18'h00010)] = 16'h1111;
        memModel[int'(18'h00011)] = 16'h2222;
        memModel[int'(18'h00200)] = 16'hAAAA;
        memModel[int'(18'h00201)] = 16'hBBBB;

        repeat (3) @(negedge clk);
        checkOutput("reset_cpu_resp", 32'(cpu_resp), 32'd0);
        checkOutput("reset_cpu_busy", 32'(cpu_busy), 32'd0);
        checkOutput("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("reset_mem_cmd", 32'(mem_cmd), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;

        // Cold read miss, clean fill
        expectMem(2'd1, 18'h00010, 16'h0, 16'h0);
        applyStimulus(2'd1, 18'h00010, 16'h0, 16'h1111, 5, 1'b0);
        // Read hit on the other word of the line
        applyStimulus(2'd1, 18'h00011, 16'h0, 16'h2222, 2, 1'b0);
        // Write hit makes the line dirty
        applyStimulus(2'd2, 18'h00011, 16'hBEEF, 16'h0, 2, 1'b0);
        // Conflicting read: write back the dirty line, then fill
        expectMem(2'd2, 18'h00010, 16'h1111, 16'hBEEF);
        expectMem(2'd1, 18'h00090, 16'h0, 16'h0);
        applyStimulus(2'd1, 18'h00090, 16'h0, memRead(18'h00090), 8, 1'b0);
`ifdef CACHE_STATS_EN
        checkOutput("hit_count", 32'(hit_count), 32'd2);
        checkOutput("miss_count", 32'(miss_count), 32'd2);
`endif

        // Write miss allocates and merges
        expectMem(2'd1, 18'h00200, 16'h0, 16'h0);
        applyStimulus(2'd2, 18'h00200, 16'hCAFE, 16'h0, 5, 1'b0);
        applyStimulus(2'd1, 18'h00200, 16'h0, 16'hCAFE, 2, 1'b0);
        applyStimulus(2'd1, 18'h00201, 16'h0, 16'hBBBB, 2, 1'b0);

        // Index wrap and a slower memory
        memLatency = 2;
        expectMem(2'd1, 18'h3FFFE, 16'h0, 16'h0);
        applyStimulus(2'd1, 18'h3FFFF, 16'h0, memRead(18'h3FFFF), 6, 1'b0);
        expectMem(2'd2, 18'h00200, 16'hCAFE, 16'hBBBB);
        expectMem(2'd1, 18'h00000, 16'h0, 16'h0);
        applyStimulus(2'd1, 18'h00000, 16'h0, memRead(18'h00000), 10, 1'b0);
        applyStimulus(2'd1, 18'h3FFFE, 16'h0, memRead(18'h3FFFE), 2, 1'b1);
        memLatency = 1;

        // Write miss to the odd word replaces a clean line
        expectMem(2'd1, 18'h00400, 16'h0, 16'h0);
        applyStimulus(2'd2, 18'h00401, 16'h1234, 16'h0, 5, 1'b0);
        applyStimulus(2'd1, 18'h00400, 16'h0, memRead(18'h00400), 2, 1'b0);
        applyStimulus(2'd1, 18'h00401, 16'h0, 16'h1234, 2, 1'b0);

        // Reset while waiting for a fill: no response, everything cleared
        memLatency = 20;
        expectMem(2'd1, 18'h00050, 16'h0, 16'h0);
        @(negedge clk);
        cpu_cmd  = 2'd1;
        cpu_addr = 18'h00051;
        @(posedge clk);
        #1 cpu_cmd = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("busy_in_fill_wait", 32'(cpu_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_cpu_resp", 32'(cpu_resp), 32'd0);
        checkOutput("abort_cpu_busy", 32'(cpu_busy), 32'd0);
        checkOutput("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("abort_mem_cmd", 32'(mem_cmd), 32'd0);
        checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        memLatency = 1;

        // Valid bits were cleared, so this line misses again
        expectMem(2'd1, 18'h00010, 16'h0, 16'h0);
        applyStimulus(2'd1, 18'h00010, 16'h0, 16'h1111, 5, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("pending_mem_txns", 32'(expMem.size()), 32'd0);
        checkOutput("pending_cpu_resps", 32'(expCpu.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_dm_wb.md
Name: cache_dm_wb

Overview:
- Direct-mapped, write-back, write-allocate cache between the CPU request bus and the Mem block.
- Accepts single-word CPU reads and writes.
- Serves hits from internal arrays.
- On a miss it writes back a dirty victim line, then fills the line from memory, using two-word bursts on the memory-side bus.

Parameters:
ADDR_W, 18, word address width (CPU and memory side)
DATA_W, 16, data word width
SETS, 64, number of lines; index width log2(SETS)=6
LINE_WORDS, 2, words per line (fixed at 2; offset = addr[0])

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
cpu_cmd  in  2  0 NOP, 1 READ, 2 WRITE, 3 reserved (treated as NOP)
cpu_addr  in  ADDR_W  word address, sampled with cpu_cmd
cpu_wdata  in  DATA_W  write data, sampled with cpu_cmd
cpu_rdata  out  DATA_W  read data, valid while cpu_resp=1
cpu_resp  out  1  one-cycle completion pulse
cpu_busy  out  1  1 when a request is in flight; cpu_cmd is ignored while 1
mem_cmd  out  2  0 NOP, 1 READ_LINE, 2 WRITE_LINE
mem_addr  out  ADDR_W  line base address (bit0=0), valid while mem_cmd!=0
mem_wdata  out  DATA_W  write-back burst data
mem_rdata  in  DATA_W  fill burst data
mem_resp  in  1  memory completion pulse

Behaviour:
- Address split: offset=addr[0], index=addr[6:1], tag=addr[17:7]. Per line: valid, dirty, tag, 2 data words.
- Reset, asynchronous: all valid and dirty bits clear, state=IDLE; cpu_resp=0, cpu_busy=0, cpu_rdata=0, mem_cmd=0, mem_addr=0, mem_wdata=0.
  - Any in-flight request is dropped; no cpu_resp is issued for it.
- States: IDLE, LOOKUP, WB_CMD, WB_D1, WB_WAIT, FILL_CMD, FILL_WAIT, FILL_D1, RESP.
- IDLE: cpu_cmd in {1,2} latches addr, wdata and op; goes to LOOKUP; cpu_busy=1 from the next cycle.
- LOOKUP: hit = valid && tag match.
  - Hit read: cpu_rdata = word[offset].
  - Hit write: word[offset] = wdata, dirty=1.
  - Hit goes to RESP.
  - Miss with valid&&dirty goes to WB_CMD; otherwise goes to FILL_CMD.
- WB_CMD: mem_cmd=2 for exactly one cycle; mem_addr = {victim tag, index, 0}; mem_wdata = word0. Next state WB_D1.
- WB_D1: mem_wdata = word1, mem_cmd=0. Next state WB_WAIT.
- WB_WAIT: wait for mem_resp, with no timeout; then dirty=0 and go to FILL_CMD.
- FILL_CMD: mem_cmd=1 for one cycle; mem_addr = {req tag, index, 0}. Next state FILL_WAIT.
- FILL_WAIT: on mem_resp, capture mem_rdata as word0. Next state FILL_D1.
- FILL_D1: capture mem_rdata as word1; set tag, valid=1, dirty=0. Then apply the pending op:
  - read returns the filled word[offset];
  - write merges wdata and sets dirty=1.
  - Next state RESP.
- RESP: cpu_resp=1 for one cycle; cpu_busy falls in the same cycle. Next state IDLE. cpu_rdata holds its value until the next response.
- Latency, accept edge to cpu_resp: hit = 2 cycles. Miss = 2 + memory wait cycles + 2 (clean) or + 3 + write-back wait (dirty).
- A mem_resp arriving outside WB_WAIT/FILL_WAIT is ignored.
- A cpu_cmd asserted in the same cycle as cpu_resp is ignored; a new command is accepted the cycle after.
- Index wrap: addresses 0x3FFFF and 0x00000 map to distinct lines (indices 63 and 0). No special case.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count [15:0] and miss_count [15:0].
  - hit_count increments in LOOKUP on a hit; miss_count increments in LOOKUP on a miss.
  - Both saturate at 0xFFFF and clear on Reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold read 0x00010 after Reset -> mem_cmd=1, mem_addr=0x00010. Memory returns 0x1111, 0x2222 -> cpu_resp with cpu_rdata=0x1111; no mem_cmd=2 issued.
- Read 0x00011 immediately after -> hit: cpu_resp 2 cycles after accept, cpu_rdata=0x2222, mem_cmd stays 0.
- Write 0x00011=0xBEEF (hit), then read 0x00090 (index 8, tag 1):
  - mem_cmd=2 at mem_addr=0x00010, mem_wdata 0x1111 then 0xBEEF;
  - then mem_cmd=1 at mem_addr=0x00090.
- Write miss to 0x00200 with 0xCAFE; fill returns 0xAAAA, 0xBBBB -> read 0x00200 hits 0xCAFE, read 0x00201 hits 0xBBBB.
- Assert Reset during FILL_WAIT of a read -> outputs zero immediately, no cpu_resp. Re-reading 0x00010 misses (mem_cmd=1), proving valid bits were cleared.
- With CACHE_STATS_EN: run the first three scenarios -> hit_count=2, miss_count=2.
